// File: rtl/fxp_accum.sv
// fxp_accum: signed fixed-point running-sum accumulator (discrete integrator).
//
// Each accepted sample is added into a guard-bit-extended accumulator; the
// new sum is narrowed to BIT_WIDTH and presented on a registered output.
// The accumulator is never clamped to BIT_WIDTH, so the guard bits let an
// out-of-range partial sum come back into range later.
//
// Handshake: a transfer happens on a rising CLK edge when valid and ready
// are both high. in_ready is combinational: it is high when clear is low and
// the output register is empty or being drained this cycle. in_ready never
// depends on in_valid. out_valid stays high until out_ready is seen.
//
// Parameters:
//   BIT_WIDTH  - width of sample a and sum y (two's complement)
//   GUARD_BITS - extra MSBs inside the accumulator
//   SATURATE   - 1: clamp on overflow, 0: two's-complement wrap
// Ports:
//   CLK       - clock, rising edge
//   RST       - synchronous active-high reset
//   clear     - synchronous accumulator clear (blocks in_ready)
//   in_valid  - sample a is valid
//   in_ready  - sample accepted this cycle when in_valid is high
//   a         - signed input sample
//   out_valid - y holds an unconsumed sum
//   out_ready - downstream consumes y this cycle
//   y         - registered, narrowed running sum
//   ovf       - sticky overflow/saturation flag (cleared by RST or clear)
module fxp_accum #(
   parameter int BIT_WIDTH  = 16,
   parameter int GUARD_BITS = 4,
   parameter bit SATURATE   = 1'b1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_WIDTH-1:0] a,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BIT_WIDTH-1:0] y,
   output logic                 ovf
);

   localparam int ACC_W = BIT_WIDTH + GUARD_BITS;

   localparam logic [ACC_W-1:0]     ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0]     ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [BIT_WIDTH-1:0] Y_MAX   = {1'b0, {(BIT_WIDTH-1){1'b1}}};
   localparam logic [BIT_WIDTH-1:0] Y_MIN   = {1'b1, {(BIT_WIDTH-1){1'b0}}};

   logic [ACC_W-1:0]     r_acc;
   logic [BIT_WIDTH-1:0] r_y;
   logic                 r_out_valid;
   logic                 r_ovf;

   logic                 w_in_ready;
   logic                 w_acc_en;
   logic [ACC_W:0]       w_a_ext;
   logic [ACC_W:0]       w_sum;
   logic                 w_acc_ovf;
   logic [ACC_W-1:0]     w_acc_next;
   logic [GUARD_BITS:0]  w_upper;
   logic                 w_y_ovf;
   logic [BIT_WIDTH-1:0] w_y_next;

   assign w_in_ready = !clear && (!r_out_valid || out_ready);
   assign w_acc_en   = in_valid && w_in_ready;

   // One extra bit of headroom so the raw sum can never wrap.
   assign w_a_ext = {{(ACC_W + 1 - BIT_WIDTH){a[BIT_WIDTH-1]}}, a};
   assign w_sum   = {r_acc[ACC_W-1], r_acc} + w_a_ext;

   // The sum left the ACC_W signed range when its top two bits disagree;
   // the top bit then gives the true sign, i.e. the clamp direction.
   assign w_acc_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

   always_comb begin
      w_acc_next = w_sum[ACC_W-1:0];
      if (w_acc_ovf && SATURATE)
         w_acc_next = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
   end

   // The new accumulator fits in BIT_WIDTH only if every bit from the
   // narrow sign bit upward is a copy of the same value.
   assign w_upper = w_acc_next[ACC_W-1:BIT_WIDTH-1];
   assign w_y_ovf = !((&w_upper) || !(|w_upper));

   always_comb begin
      w_y_next = w_acc_next[BIT_WIDTH-1:0];
      if (w_y_ovf && SATURATE)
         w_y_next = w_acc_next[ACC_W-1] ? Y_MIN : Y_MAX;
   end

   always_ff @(posedge CLK) begin
      if (RST || clear) begin
         r_acc       <= '0;
         r_y         <= '0;
         r_out_valid <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (w_acc_en) begin
         r_acc       <= w_acc_next;
         r_y         <= w_y_next;
         r_out_valid <= 1'b1;
         if (w_acc_ovf || w_y_ovf)
            r_ovf <= 1'b1;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign y         = r_y;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_fxp_accum.sv
module tb_fxp_accum;

   logic               CLK = 1'b0;
   logic               RST;
   logic               clear;
   logic               in_valid;
   logic               out_ready;
   logic signed [15:0] a;

   // Default configuration (16/4/saturate)
   logic               in_ready;
   logic               out_valid;
   logic signed [15:0] y;
   logic               ovf;

   // No guard bits, saturating
   logic               g0s_in_ready;
   logic               g0s_out_valid;
   logic signed [15:0] g0s_y;
   logic               g0s_ovf;

   // No guard bits, wrapping
   logic               g0w_in_ready;
   logic               g0w_out_valid;
   logic signed [15:0] g0w_y;
   logic               g0w_ovf;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   fxp_accum dut (
      .CLK(CLK), .RST(RST), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .a(a),
      .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf)
   );

   fxp_accum #(.BIT_WIDTH(16), .GUARD_BITS(0), .SATURATE(1'b1)) dut_g0s (
      .CLK(CLK), .RST(RST), .clear(clear),
      .in_valid(in_valid), .in_ready(g0s_in_ready), .a(a),
      .out_valid(g0s_out_valid), .out_ready(out_ready), .y(g0s_y), .ovf(g0s_ovf)
   );

   fxp_accum #(.BIT_WIDTH(16), .GUARD_BITS(0), .SATURATE(1'b0)) dut_g0w (
      .CLK(CLK), .RST(RST), .clear(clear),
      .in_valid(in_valid), .in_ready(g0w_in_ready), .a(a),
      .out_valid(g0w_out_valid), .out_ready(out_ready), .y(g0w_y), .ovf(g0w_ovf)
   );

   // Advance past one rising edge; inputs change and outputs are sampled 1ns later.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input int exp_y,
                            input logic exp_v, input logic exp_o);
      check({tag, "_y"},   y,         exp_y);
      check({tag, "_vld"}, out_valid, exp_v);
      check({tag, "_ovf"}, ovf,       exp_o);
   endtask

   initial begin
      RST = 1'b1; clear = 1'b0; in_valid = 1'b1; out_ready = 1'b1; a = 16'sd55;

      // Reset held two cycles with a sample offered: nothing is accepted
      step();
      step();
      check_out("rst", 0, 1'b0, 1'b0);
      RST = 1'b0; in_valid = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1);

      // Streaming, out_ready held high
      in_valid = 1'b1; a = 16'sd100;
      step(); check_out("s0", 100, 1'b1, 1'b0);
      a = -16'sd30;
      step(); check_out("s1", 70, 1'b1, 1'b0);
      a = 16'sd5;
      step(); check_out("s2", 75, 1'b1, 1'b0);
      in_valid = 1'b0;
      step(); check("s_drain_vld", out_valid, 0);

      // Clear returns everything to zero
      clear = 1'b1;
      step(); check_out("clr", 0, 1'b0, 1'b0);
      clear = 1'b0;

      // Backpressure: y and out_valid hold, in_ready low
      in_valid = 1'b1; a = 16'sd10;
      step(); check_out("bp0", 10, 1'b1, 1'b0);
      out_ready = 1'b0; a = 16'sd7;
      for (int i = 0; i < 3; i++) begin
         #1; check("bp_in_ready_lo", in_ready, 0);
         step(); check_out("bp_hold", 10, 1'b1, 1'b0);
      end
      out_ready = 1'b1;
      #1; check("bp_in_ready_hi", in_ready, 1);
      step(); check_out("bp_rel", 17, 1'b1, 1'b0);
      in_valid = 1'b0;
      step();

      // Clear colliding with an offered sample
      clear = 1'b1; step(); clear = 1'b0;
      in_valid = 1'b1; a = 16'sd500;
      step(); check_out("cc_load", 500, 1'b1, 1'b0);
      clear = 1'b1; a = 16'sd9;
      #1; check("cc_in_ready", in_ready, 0);
      step(); check_out("cc_clr", 0, 1'b0, 1'b0);
      clear = 1'b0;
      #1; check("cc_in_ready_rel", in_ready, 1);
      step(); check_out("cc_rel", 9, 1'b1, 1'b0);
      in_valid = 1'b0;
      step();

      // Output saturation with guard bits; accumulator re-enters range
      clear = 1'b1; step(); clear = 1'b0;
      in_valid = 1'b1; a = 16'sd32767;
      step(); check_out("osat0", 32767, 1'b1, 1'b0);
      step(); check_out("osat1", 32767, 1'b1, 1'b1);
      a = -16'sd32768;
      step(); check_out("osat2", 32766, 1'b1, 1'b1);
      in_valid = 1'b0;
      step();

      // Negative output saturation
      clear = 1'b1; step(); clear = 1'b0;
      in_valid = 1'b1; a = -16'sd32768;
      step(); check_out("nsat0", -32768, 1'b1, 1'b0);
      a = -16'sd1;
      step(); check_out("nsat1", -32768, 1'b1, 1'b1);
      in_valid = 1'b0;
      step();

      // Accumulator overflow with no guard bits: saturate vs wrap
      clear = 1'b1; step(); clear = 1'b0;
      in_valid = 1'b1; a = 16'sd32767;
      step();
      check("g0s_y0",   g0s_y,   32767); check("g0s_ovf0", g0s_ovf, 0);
      check("g0w_y0",   g0w_y,   32767); check("g0w_ovf0", g0w_ovf, 0);
      a = 16'sd1;
      step();
      check("g0s_y1",   g0s_y,   32767);  check("g0s_ovf1", g0s_ovf, 1);
      check("g0w_y1",   g0w_y,   -32768); check("g0w_ovf1", g0w_ovf, 1);
      check("g0s_vld1", g0s_out_valid, 1);
      check("g0w_vld1", g0w_out_valid, 1);
      in_valid = 1'b0;
      step();

      // Reset mid-stream discards the pending output and clears ovf
      RST = 1'b1; step(); RST = 1'b0;
      check_out("rst2", 0, 1'b0, 1'b0);
      check("rst2_g0w_ovf", g0w_ovf, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
